iob_fp_mul_issue: RTL and testbench

//  Issue/collect stage wrapped around the pipelined FP multiplier (start/done, no backpressure).

---
 rtl/iob_fp_mul_issue.sv | 182 ++++++++++++++++++
 tb/tb_iob_fp_mul_issue.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_fp_mul_issue.sv
// rtl/iob_fp_mul_issue.sv - issue/collect stage around a pipelined FP multiplier with credit-guarded result FIFO
module iob_fp_mul_issue #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_op_a_i,
    input  logic [DATA_W-1:0] in_op_b_i,
    output logic              mul_start_o,
    output logic [DATA_W-1:0] mul_op_a_o,
    output logic [DATA_W-1:0] mul_op_b_o,
    input  logic              mul_done_i,
    input  logic [DATA_W-1:0] mul_res_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_res_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              init_done_q;
    logic [CNT_W-1:0]  inflight_q;
    logic [CNT_W-1:0]  fifo_count_q;
    logic [CNT_W-1:0]  credits;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic accept;
    logic pop;
    logic fifo_full;
    logic fifo_wr;
    logic fifo_clr;
    logic inflight_dec;
    logic overrun_evt;

    // Every slot is either travelling through the multiplier or parked in the FIFO;
    // what is left over is how many new operations may still be started.
    assign credits   = DEPTH_C - inflight_q - fifo_count_q;
    assign fifo_full = (fifo_count_q == DEPTH_C);

    // Next state plus the handshake outputs that depend on the mode.
    always_comb begin
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        fifo_clr    = 1'b0;
        case (state_q)
            S_RUN: begin
                // A flush request also closes the input in its own cycle so no
                // start can be launched once the drain has begun.
                in_ready_o  = init_done_q && (credits != '0) && !flush_i;
                out_valid_o = (fifo_count_q != '0);
                if (flush_i) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                fifo_clr = 1'b1;
                if (inflight_q == '0) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign accept       = in_valid_i && in_ready_o;
    assign pop          = out_valid_o && out_ready_i;
    // A pop in the same cycle frees the head slot, so a done on a full FIFO is still stored.
    assign fifo_wr      = mul_done_i && (state_q == S_RUN) && (!fifo_full || pop);
    assign overrun_evt  = mul_done_i && (state_q == S_RUN) && fifo_full && !pop;
    // A stray done with nothing outstanding must not wrap the counter.
    assign inflight_dec = mul_done_i && (inflight_q != '0);

    assign out_res_o = mem_q[rd_ptr_q];
    assign busy_o    = (inflight_q != '0) || (fifo_count_q != '0) || (state_q == S_FLUSH);

    // Mode register; init_done keeps the input closed for the first cycle after reset release.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= 1'b1;
        end
    end

    // Register accepted operands onto the multiplier and fire a one-cycle start.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mul_start_o <= 1'b0;
            mul_op_a_o  <= '0;
            mul_op_b_o  <= '0;
        end else begin
            mul_start_o <= accept;
            if (accept) begin
                mul_op_a_o <= in_op_a_i;
                mul_op_b_o <= in_op_b_i;
            end
        end
    end

    // Count operations started but not yet returned by the multiplier.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= '0;
        end else begin
            case ({accept, inflight_dec})
                2'b10:   inflight_q <= inflight_q + ONE_C;
                2'b01:   inflight_q <= inflight_q - ONE_C;
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; the flush mode holds them at empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else if (fifo_clr) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({fifo_wr, pop})
                2'b10:   fifo_count_q <= fifo_count_q + ONE_C;
                2'b01:   fifo_count_q <= fifo_count_q - ONE_C;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // Result storage in completion order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fifo_wr) begin
            mem_q[wr_ptr_q] <= mul_res_i;
        end
    end

    // Sticky flag for a result that arrived with nowhere to go.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            overrun_o <= 1'b0;
        end else if (overrun_evt) begin
            overrun_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_iob_fp_mul_issue.sv
// tb/tb_iob_fp_mul_issue.sv - scoreboard bench for the FP multiplier issue/collect stage
module tb_iob_fp_mul_issue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_op_a_i;
    logic [DATA_W-1:0] in_op_b_i;
    logic              mul_start_o;
    logic [DATA_W-1:0] mul_op_a_o;
    logic [DATA_W-1:0] mul_op_b_o;
    logic              mul_done_i;
    logic [DATA_W-1:0] mul_res_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DATA_W-1:0] out_res_o;
    logic              busy_o;
    logic              overrun_o;

    iob_fp_mul_issue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_op_a_i(in_op_a_i), .in_op_b_i(in_op_b_i),
        .mul_start_o(mul_start_o), .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o),
        .mul_done_i(mul_done_i), .mul_res_i(mul_res_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_res_o(out_res_o),
        .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'hFF) || (b[30:23] == 8'hFF);
    endfunction

    // IEEE single multiply for operands whose product is exact (no rounding needed).
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [47:0] p;
        logic [22:0] m;
        int          e;
        s = a[31] ^ b[31];
        if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
            return 32'h7FC00000;
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
            if (a[30:0] == 0 || b[30:0] == 0) return 32'h7FC00000;
            return {s, 8'hFF, 23'h0};
        end
        if (a[30:23] == 0 || b[30:23] == 0) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e = e + 1;
        end else begin
            m = p[45:23];
        end
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] int_to_fp(input int v);
        logic        s;
        logic [31:0] m;
        int          msb;
        s   = (v < 0);
        m   = s ? 32'(-v) : 32'(v);
        msb = 0;
        for (int i = 0; i < 32; i++) if (m[i]) msb = i;
        return {s, 8'(127 + msb), 23'((m << (23 - msb)) & 32'h007FFFFF)};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int v;
        v = int'($urandom_range(1, 1000));
        if ($urandom_range(0, 1) == 1) v = -v;
        return int_to_fp(v);
    endfunction

    // Results leave in completion order: issue cycle plus the operation's latency.
    function automatic void sb_push(input int due, input logic [31:0] v);
        exp_t e;
        int   idx;
        e.due = due;
        e.val = v;
        idx   = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].due > due) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Multiplier model: 4-cycle latency, 1 cycle when an operand is NaN/Inf.
    logic        model_done = 1'b0;
    logic [31:0] model_res  = '0;
    logic        force_done;
    logic [31:0] force_res;
    bit          pend_v   [16];
    logic [31:0] pend_res [16];
    int          slot;

    assign mul_done_i = model_done | force_done;
    assign mul_res_i  = force_done ? force_res : model_res;

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 16; i++) pend_v[i] = 1'b0;
            model_done = 1'b0;
        end else begin
            model_done         = pend_v[cyc % 16];
            model_res          = pend_res[cyc % 16];
            pend_v[cyc % 16]   = 1'b0;
            if (mul_start_o) begin
                slot           = (cyc + (is_special(mul_op_a_o, mul_op_b_o) ? 1 : 4)) % 16;
                pend_v[slot]   = 1'b1;
                pend_res[slot] = fp_mul(mul_op_a_o, mul_op_b_o);
            end
        end
    end

    // Output monitor.
    exp_t got_e;
    always @(negedge clk_i) begin
        #2;
        if (rst_n_i && out_valid_o && out_ready_i) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_output got=%h expected=none", out_res_o);
            end else begin
                got_e = sb.pop_front();
                if (out_res_o !== got_e.val) begin
                    bad++;
                    $display("FAIL result_order got=%h expected=%h", out_res_o, got_e.val);
                end
            end
        end
    end

    task automatic issue(input bit v, input logic [31:0] a, input logic [31:0] b, output bit acc);
        @(negedge clk_i);
        in_valid_i = v;
        in_op_a_i  = a;
        in_op_b_i  = b;
        #1;
        acc = v && in_ready_o;
        if (acc) sb_push(cyc + 1 + (is_special(a, b) ? 1 : 4), fp_mul(a, b));
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        @(negedge clk_i);
        in_valid_i = 1'b0;
        #1;
        while (busy_o && n < budget) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check(name, 32'(busy_o), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_ready_o),  32'd0);
        check({tag, "_mul_start"}, 32'(mul_start_o), 32'd0);
        check({tag, "_mul_op_a"},  mul_op_a_o,       32'd0);
        check({tag, "_mul_op_b"},  mul_op_b_o,       32'd0);
        check({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        check({tag, "_out_res"},   out_res_o,        32'd0);
        check({tag, "_busy"},      32'(busy_o),      32'd0);
        check({tag, "_overrun"},   32'(overrun_o),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n_acc;
        rst_n_i     = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_op_a_i   = '0;
        in_op_b_i   = '0;
        out_ready_i = 1'b0;
        force_done  = 1'b0;
        force_res   = '0;
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_outputs("por");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Reset mid-stream with three operations in flight.
        out_ready_i = 1'b1;
        n_acc = 0;
        for (int k = 0; k < 20 && n_acc < 3; k++) begin
            issue(1'b1, rnd_fp(), rnd_fp(), acc);
            n_acc += int'(acc);
        end
        check("midrst_accepts", 32'(n_acc), 32'd3);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        rst_n_i    = 1'b0;
        #1;
        check_reset_outputs("midrst");
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_n_i     = 1'b1;
        out_ready_i = 1'b0;

        // Credits are back to DEPTH: exactly 8 accepted with the consumer stalled.
        n_acc = 0;
        for (int k = 0; k < 30; k++) begin
            issue(1'b1, rnd_fp(), rnd_fp(), acc);
            n_acc += int'(acc);
        end
        check("credit_accepts", 32'(n_acc), 32'd8);
        check("credit_ready_low", 32'(in_ready_o), 32'd0);
        @(negedge clk_i);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk_i);
        out_ready_i = 1'b0;
        n_acc = 0;
        for (int k = 0; k < 20; k++) begin
            issue(1'b1, rnd_fp(), rnd_fp(), acc);
            n_acc += int'(acc);
        end
        check("credit_after_pop", 32'(n_acc), 32'd1);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        #1;
        check("full_out_valid", 32'(out_valid_o), 32'd1);
        check("full_no_overrun", 32'(overrun_o), 32'd0);

        // Stray done on a full FIFO with no pop.
        @(negedge clk_i);
        force_done = 1'b1;
        force_res  = 32'hDEADBEEF;
        @(negedge clk_i);
        force_done = 1'b0;
        #1;
        check("overrun_set", 32'(overrun_o), 32'd1);
        repeat (3) @(negedge clk_i);
        #1;
        check("overrun_sticky", 32'(overrun_o), 32'd1);
        check("overrun_head_kept", out_res_o, sb[0].val);
        out_ready_i = 1'b1;
        wait_idle(50, "overrun_drain_idle");
        check("overrun_drain_empty", 32'(sb.size()), 32'd0);
        check("overrun_after_drain", 32'(overrun_o), 32'd1);

        // Sustained stream: 16 back-to-back accepts.
        n_acc = 0;
        issue(1'b1, 32'h40000000, 32'h40400000, acc);
        n_acc += int'(acc);
        for (int k = 1; k < 16; k++) begin
            issue(1'b1, rnd_fp(), rnd_fp(), acc);
            n_acc += int'(acc);
        end
        check("stream_accepts", 32'(n_acc), 32'd16);
        wait_idle(50, "stream_idle");
        check("stream_sb_empty", 32'(sb.size()), 32'd0);

        // A NaN issued one cycle later completes first.
        out_ready_i = 1'b0;
        issue(1'b1, 32'h3FC00000, 32'h40000000, acc);
        check("ovt_accept_a", 32'(acc), 32'd1);
        issue(1'b1, 32'h7FC00000, 32'h3F800000, acc);
        check("ovt_accept_b", 32'(acc), 32'd1);
        issue(1'b0, 32'h0, 32'h0, acc);
        repeat (10) @(negedge clk_i);
        #1;
        check("ovt_head_nan", out_res_o, 32'h7FC00000);
        out_ready_i = 1'b1;
        wait_idle(50, "ovt_idle");
        check("ovt_sb_empty", 32'(sb.size()), 32'd0);

        // Flush with three operations in flight: nothing may come out.
        n_acc = 0;
        for (int k = 0; k < 20 && n_acc < 3; k++) begin
            issue(1'b1, rnd_fp(), rnd_fp(), acc);
            n_acc += int'(acc);
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        flush_i    = 1'b1;
        sb.delete();
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("flush_ready_low", 32'(in_ready_o), 32'd0);
        check("flush_busy", 32'(busy_o), 32'd1);
        wait_idle(50, "flush_idle");
        check("flush_ready_back", 32'(in_ready_o), 32'd1);
        check("flush_out_valid", 32'(out_valid_o), 32'd0);

        // Stray done with nothing in flight is still enqueued; the counter must not wrap.
        @(negedge clk_i);
        force_done = 1'b1;
        force_res  = 32'h12345678;
        sb_push(cyc, 32'h12345678);
        @(negedge clk_i);
        force_done = 1'b0;
        wait_idle(20, "stray_idle");
        check("stray_sb_empty", 32'(sb.size()), 32'd0);

        // Random traffic with random consumer stalls.
        for (int k = 0; k < 200; k++) begin
            issue($urandom_range(0, 3) != 0, rnd_fp(), rnd_fp(), acc);
            out_ready_i = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk_i);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        wait_idle(100, "random_idle");
        check("random_sb_empty", 32'(sb.size()), 32'd0);
        check("random_no_overrun_change", 32'(overrun_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
